// File: rtl/data_memory_pipelined_if.sv
// Request/response bundle for data_memory_pipelined: valid/ready request channel
// plus an in-order response channel that has no backpressure.
interface data_memory_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_pipelined.sv
// Word-addressed data memory with byte-enable writes, a zeroing sweep after reset,
// out-of-range error reporting and an in-order response pipeline of RD_LAT stages.
module data_memory_pipelined #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  data_memory_pipelined_if.slave bus,
  output logic                   busy
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic              clr_en;
  logic [IDX_W-1:0]  idx;

  // Stage k holds a response k+1 edges after acceptance; h marks "carries read data".
  logic [RD_LAT-1:0] v_pipe;
  logic [RD_LAT-1:0] e_pipe;
  logic [RD_LAT-1:0] h_pipe;
  logic [DATA_W-1:0] d_pipe [RD_LAT];

  assign bus.req_ready = (state_reg == RUN) && !reset;
  assign busy          = (state_reg == CLEAR) || reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = bus.req_addr < ADDR_W'(DEPTH);
  assign idx           = bus.req_addr[IDX_W-1:0];
  assign wr_en         = accept && bus.req_we && in_range;
  assign rd_en         = accept && !bus.req_we && in_range;
  assign clr_en        = (state_reg == CLEAR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else if (state_reg == CLEAR) begin
      ptr_reg <= ptr_reg + 1'b1;
      if (ptr_reg == IDX_W'(DEPTH - 1)) begin
        state_reg <= RUN;
      end
    end
  end

  // Reads sample the array before this edge's write lands, which is exactly
  // "all previously accepted writes" since only one request is taken per cycle.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[ptr_reg] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_be[b]) begin
          mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      d_pipe[0] <= mem[idx];
    end
  end

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            v_pipe[0] <= 1'b0;
            e_pipe[0] <= 1'b0;
            h_pipe[0] <= 1'b0;
          end else begin
            v_pipe[0] <= accept;
            e_pipe[0] <= accept && !in_range;
            h_pipe[0] <= rd_en;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          d_pipe[gi] <= d_pipe[gi-1];
          if (reset) begin
            v_pipe[gi] <= 1'b0;
            e_pipe[gi] <= 1'b0;
            h_pipe[gi] <= 1'b0;
          end else begin
            v_pipe[gi] <= v_pipe[gi-1];
            e_pipe[gi] <= e_pipe[gi-1];
            h_pipe[gi] <= h_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

  // Gating with reset hides any in-flight response during the reset cycle itself.
  assign bus.rsp_valid = v_pipe[RD_LAT-1] && !reset;
  assign bus.rsp_err   = e_pipe[RD_LAT-1] && !reset;
  assign bus.rsp_rdata = (h_pipe[RD_LAT-1] && !reset) ? d_pipe[RD_LAT-1] : '0;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench: four memories with RD_LAT 1..4 share one stimulus stream and are checked
// every cycle against a queue-based reference model, plus literal spot checks.
module tb_data_memory_pipelined;
  localparam int DEPTH = 32;
  localparam int NL    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        busy_w  [NL];
  logic        ready_w [NL];
  logic        valid_w [NL];
  logic        err_w   [NL];
  logic [31:0] rdata_w [NL];

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      data_memory_pipelined_if #(.DATA_W(32), .ADDR_W(32)) bus ();
      assign bus.req_valid = req_valid;
      assign bus.req_we    = req_we;
      assign bus.req_addr  = req_addr;
      assign bus.req_wdata = req_wdata;
      assign bus.req_be    = req_be;
      assign ready_w[gi]   = bus.req_ready;
      assign valid_w[gi]   = bus.rsp_valid;
      assign err_w[gi]     = bus.rsp_err;
      assign rdata_w[gi]   = bus.rsp_rdata;

      data_memory_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RD_LAT(gi + 1)
      ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy_w[gi])
      );
    end
  endgenerate

  typedef struct {
    int          edge0;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        acc_q[$];
  int          head       [NL];
  int          vcount     [NL];
  int          first_edge [NL];
  int          last_edge  [NL];
  logic [31:0] last_rdata [NL];
  logic        last_err   [NL];
  logic [31:0] mmem       [DEPTH];
  int          edge_cnt = 0;
  int          rel_cnt  = 0;
  int          bcount   = 0;
  int          n_cmp    = 0;
  int          n_err    = 0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rel_cnt  <= reset ? 0 : ((rel_cnt < 1000) ? rel_cnt + 1 : rel_cnt);
  end

  // Reference: clear lasts DEPTH edges after reset falls; a request accepted at
  // the edge after drive-time edge e0 is visible while edge_cnt == e0 + RD_LAT.
  always @(negedge clk) begin
    if (checking) begin
      logic exp_busy;
      exp_busy = reset || (rel_cnt < DEPTH);
      for (int l = 0; l < NL; l++) begin
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        ev = 1'b0;
        ed = '0;
        ee = 1'b0;
        if (!reset && head[l] < acc_q.size() && acc_q[head[l]].edge0 + l + 1 == edge_cnt) begin
          ev = 1'b1;
          ed = acc_q[head[l]].data;
          ee = acc_q[head[l]].err;
          head[l]++;
        end
        chk($sformatf("lane%0d busy", l), {31'b0, busy_w[l]}, {31'b0, exp_busy});
        chk($sformatf("lane%0d req_ready", l), {31'b0, ready_w[l]}, {31'b0, !exp_busy});
        chk($sformatf("lane%0d rsp_valid", l), {31'b0, valid_w[l]}, {31'b0, ev});
        chk($sformatf("lane%0d rsp_rdata", l), rdata_w[l], ed);
        chk($sformatf("lane%0d rsp_err", l), {31'b0, err_w[l]}, {31'b0, ee});
        if (valid_w[l] === 1'b1) begin
          if (vcount[l] == 0) first_edge[l] = edge_cnt;
          last_edge[l]  = edge_cnt;
          last_rdata[l] = rdata_w[l];
          last_err[l]   = err_w[l];
          vcount[l]++;
        end
        if (l == 0 && !reset && busy_w[l] === 1'b1) bcount++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int l = 0; l < NL; l++) begin
      vcount[l]     = 0;
      first_edge[l] = -1;
      last_edge[l]  = -1;
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    int   guard;
    guard = 0;
    while (!(reset == 1'b0 && rel_cnt >= DEPTH)) begin
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_wait: memory never became ready within 200 cycles");
        return;
      end
      idle(1);
    end
    e.edge0 = edge_cnt;
    e.err   = (addr >= 32'(DEPTH));
    e.data  = '0;
    if (!e.err) begin
      if (!we) begin
        e.data = mmem[addr[4:0]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mmem[addr[4:0]][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
    acc_q.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    idle(1);
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = 1'b0;
    for (int l = 0; l < NL; l++) head[l] = acc_q.size();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    idle(n);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int l = 0; l < NL; l++) begin
      head[l]       = 0;
      last_rdata[l] = '0;
      last_err[l]   = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    clear_counts();
    idle(2);
    checking = 1'b1;

    // Clear sweep and initial scan
    bcount = 0;
    do_reset(1);
    idle(40);
    chk("clear_busy_cycles", bcount, 32);
    clear_counts();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, a, '0, '0);
    idle(6);
    chk("scan_resp_count", vcount[0], 32);
    chk("scan_last_rdata", last_rdata[3], 32'h0);

    // Byte-enable merge
    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
    issue(1'b1, 32'd5, 32'h11223344, 4'b0101);
    issue(1'b0, 32'd5, '0, '0);
    idle(6);
    for (int l = 0; l < NL; l++) chk($sformatf("be_merge lane%0d", l), last_rdata[l], 32'hDE22BE44);

    // Back-to-back write then read, latency on RD_LAT=3
    clear_counts();
    t0 = edge_cnt;
    issue(1'b1, 32'd2, 32'hA5, 4'hF);
    issue(1'b0, 32'd2, '0, '0);
    idle(8);
    chk("lat3_resp_count", vcount[2], 2);
    chk("lat3_first_edge", first_edge[2], t0 + 3);
    chk("lat3_last_edge", last_edge[2], t0 + 4);
    chk("lat3_read_data", last_rdata[2], 32'hA5);

    // Out-of-range accesses
    issue(1'b0, 32'd32, '0, '0);
    issue(1'b1, 32'hFFFFFFFF, 32'h12345678, 4'hF);
    idle(6);
    chk("oob_err", {31'b0, last_err[0]}, 32'h1);
    chk("oob_rdata", last_rdata[0], 32'h0);
    for (int a = 0; a < DEPTH; a++) issue(1'b0, a, '0, '0);
    idle(6);

    // Reset with responses in flight
    clear_counts();
    issue(1'b1, 32'd7, 32'h55, 4'hF);
    issue(1'b0, 32'd7, '0, '0);
    issue(1'b0, 32'd7, '0, '0);
    issue(1'b0, 32'd7, '0, '0);
    do_reset(1);
    idle(40);
    for (int l = 0; l < NL; l++) chk($sformatf("drop_count lane%0d", l), vcount[l], 3 - l);
    chk("pre_reset_read", last_rdata[0], 32'h55);
    clear_counts();
    issue(1'b0, 32'd7, '0, '0);
    idle(6);
    chk("post_reset_count", vcount[3], 1);
    chk("post_reset_read", last_rdata[3], 32'h0);

    // Random traffic on all latencies at once
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 39)), $urandom, 4'($urandom_range(0, 15)));
    end
    idle(8);
    for (int l = 0; l < NL; l++) chk($sformatf("drained lane%0d", l), head[l], acc_q.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
